// File: rtl/rf_write_arbiter.sv
// Two-requester register file write arbiter with round-robin grant
// and an optional post-reset sweep that zeroes all 32 registers.
module rf_write_arbiter #(
    parameter bit INIT_CLEAR = 1'b1,
    parameter bit ZERO_R0    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [4:0]  req0_dst,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_dst,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [4:0]  Rdst,
    output logic [31:0] RY,
    output logic        RF_WRITE,
    output logic        init_busy,
    output logic        grant_last
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [4:0]  cnt_d;
    logic        swept;
    logic        swept_d;
    logic        ptr;
    logic        ptr_d;
    logic        sweep_end;
    logic        gnt0;
    logic        gnt1;
    logic        both;
    logic [4:0]  sel_dst;
    logic [31:0] sel_data;
    logic        we_d;
    logic [4:0]  dst_d;
    logic [31:0] data_d;
    logic        gl_d;
    logic        busy_d;

    // swept marks that index 31 has already been issued, so the
    // following edge leaves INIT instead of starting a second sweep
    assign sweep_end = !INIT_CLEAR || swept;
    assign both      = req0_valid && req1_valid;

    assign gnt0 = (state == RUN) && req0_valid && (!req1_valid || !ptr);
    assign gnt1 = (state == RUN) && req1_valid && (!req0_valid || ptr);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sel_dst  = 5'd0;
        sel_data = 32'd0;
        unique case (1'b1)
            gnt0:    begin sel_dst = req0_dst; sel_data = req0_data; end
            gnt1:    begin sel_dst = req1_dst; sel_data = req1_data; end
            default: begin sel_dst = 5'd0;     sel_data = 32'd0;     end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    if (sweep_end) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        we_d    = 1'b0;
        dst_d   = Rdst;
        data_d  = RY;
        gl_d    = grant_last;
        ptr_d   = ptr;
        cnt_d   = cnt;
        swept_d = swept;
        busy_d  = INIT_CLEAR && (state_nx == INIT);
        unique case (state)
            INIT: begin
                if (!sweep_end) begin
                    we_d   = 1'b1;
                    dst_d  = cnt;
                    data_d = 32'd0;
                    if (cnt == 5'd31) swept_d = 1'b1;
                    else              cnt_d   = cnt + 5'd1;
                end
            end
            RUN: begin
                if (gnt0 || gnt1) begin
                    gl_d = gnt1;
                    // contested grant hands priority to the loser
                    if (both) ptr_d = gnt0;
                    if (!(ZERO_R0 && sel_dst == 5'd0)) begin
                        we_d   = 1'b1;
                        dst_d  = sel_dst;
                        data_d = sel_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= 5'd0;
            swept      <= 1'b0;
            ptr        <= 1'b0;
            RF_WRITE   <= 1'b0;
            Rdst       <= 5'd0;
            RY         <= 32'd0;
            grant_last <= 1'b0;
            init_busy  <= INIT_CLEAR;
        end else begin
            cnt        <= cnt_d;
            swept      <= swept_d;
            ptr        <= ptr_d;
            RF_WRITE   <= we_d;
            Rdst       <= dst_d;
            RY         <= data_d;
            grant_last <= gl_d;
            init_busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: init sweep, vector table with a
// write scoreboard, reset abort and no-clear variant.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid;
    logic [4:0]  req0_dst;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_dst;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [4:0]  Rdst;
    logic [31:0] RY;
    logic        RF_WRITE;
    logic        init_busy;
    logic        grant_last;

    logic        b_req0_ready;
    logic        b_req1_ready;
    logic [4:0]  b_Rdst;
    logic [31:0] b_RY;
    logic        b_RF_WRITE;
    logic        b_init_busy;
    logic        b_grant_last;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_dst(req0_dst),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_dst(req1_dst),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .Rdst(Rdst), .RY(RY), .RF_WRITE(RF_WRITE),
        .init_busy(init_busy), .grant_last(grant_last)
    );

    rf_write_arbiter #(.INIT_CLEAR(1'b0), .ZERO_R0(1'b1)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_dst(req0_dst),
        .req0_data(req0_data), .req0_ready(b_req0_ready),
        .req1_valid(req1_valid), .req1_dst(req1_dst),
        .req1_data(req1_data), .req1_ready(b_req1_ready),
        .Rdst(b_Rdst), .RY(b_RY), .RF_WRITE(b_RF_WRITE),
        .init_busy(b_init_busy), .grant_last(b_grant_last)
    );

    typedef struct {
        logic        v0;
        logic [4:0]  d0;
        logic [31:0] x0;
        logic        v1;
        logic [4:0]  d1;
        logic [31:0] x1;
        int          g;
        logic        we;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        gl;
    } exp_t;

    vec_t        vt [13];
    exp_t        sb [$];
    logic [31:0] rf [32];
    logic [4:0]  hold_dst;
    logic [31:0] hold_data;
    logic        hold_gl;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0;
        req0_dst   = v.d0;
        req0_data  = v.x0;
        req1_valid = v.v1;
        req1_dst   = v.d1;
        req1_data  = v.x1;
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        drive(v);
        @(negedge clk);
        chk($sformatf("v%0d ready0", idx), {31'd0, req0_ready},
            {31'd0, v.g == 1});
        chk($sformatf("v%0d ready1", idx), {31'd0, req1_ready},
            {31'd0, v.g == 2});
        chk($sformatf("v%0d ready excl", idx),
            {31'd0, req0_ready && req1_ready}, 32'd0);
        if (v.g != 0) begin
            e.we   = v.we;
            e.dst  = (v.g == 1) ? v.d0 : v.d1;
            e.data = (v.g == 1) ? v.x0 : v.x1;
            e.gl   = (v.g == 2);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (RF_WRITE) rf[Rdst] = RY;
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk($sformatf("v%0d we", idx), {31'd0, RF_WRITE},
                {31'd0, got.we});
            chk($sformatf("v%0d gl", idx), {31'd0, grant_last},
                {31'd0, got.gl});
            hold_gl = got.gl;
            if (got.we) begin
                chk($sformatf("v%0d dst", idx), {27'd0, Rdst},
                    {27'd0, got.dst});
                chk($sformatf("v%0d data", idx), RY, got.data);
                hold_dst  = got.dst;
                hold_data = got.data;
            end
        end else begin
            chk($sformatf("v%0d idle we", idx), {31'd0, RF_WRITE}, 32'd0);
            chk($sformatf("v%0d hold dst", idx), {27'd0, Rdst},
                {27'd0, hold_dst});
            chk($sformatf("v%0d hold data", idx), RY, hold_data);
            chk($sformatf("v%0d hold gl", idx), {31'd0, grant_last},
                {31'd0, hold_gl});
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1, 1'b1};
        vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1'b0};
        vt[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 2, 1'b1};
        vt[3]  = '{1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1, 1'b1};
        vt[4]  = '{1'b1, 5'd4, 32'hC, 1'b1, 5'd2, 32'hB, 2, 1'b1};
        vt[5]  = '{1'b1, 5'd4, 32'hC, 1'b1, 5'd6, 32'hD, 1, 1'b1};
        vt[6]  = '{1'b1, 5'd8, 32'hE, 1'b1, 5'd6, 32'hD, 2, 1'b1};
        vt[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99, 2, 1'b0};
        vt[8]  = '{1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0, 1, 1'b0};
        vt[9]  = '{1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 1, 1'b1};
        vt[10] = '{1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 2, 1'b1};
        vt[11] = '{1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0, 1, 1'b1};
        vt[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1'b0};
        for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;

        // reset with a request already pending
        rst_n = 1'b0;
        drive(vt[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst we", {31'd0, RF_WRITE}, 32'd0);
        chk("rst dst", {27'd0, Rdst}, 32'd0);
        chk("rst data", RY, 32'd0);
        chk("rst gl", {31'd0, grant_last}, 32'd0);
        chk("rst busy", {31'd0, init_busy}, 32'd1);
        chk("rst ready0", {31'd0, req0_ready}, 32'd0);
        chk("nc rst busy", {31'd0, b_init_busy}, 32'd0);
        chk("nc rst ready0", {31'd0, b_req0_ready}, 32'd0);

        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            if (RF_WRITE) rf[Rdst] = RY;
            chk($sformatf("sweep%0d we", k), {31'd0, RF_WRITE}, 32'd1);
            chk($sformatf("sweep%0d dst", k), {27'd0, Rdst}, k);
            chk($sformatf("sweep%0d data", k), RY, 32'd0);
            chk($sformatf("sweep%0d busy", k), {31'd0, init_busy}, 32'd1);
            chk($sformatf("sweep%0d ready0", k), {31'd0, req0_ready}, 32'd0);
            if (k == 0) begin
                chk("nc run busy", {31'd0, b_init_busy}, 32'd0);
                chk("nc run ready0", {31'd0, b_req0_ready}, 32'd1);
            end
        end
        @(posedge clk);
        #1;
        chk("sweep end we", {31'd0, RF_WRITE}, 32'd0);
        chk("sweep end busy", {31'd0, init_busy}, 32'd0);
        chk("sweep end dst", {27'd0, Rdst}, 32'd31);
        hold_dst  = 5'd31;
        hold_data = 32'd0;
        hold_gl   = 1'b0;

        for (int i = 0; i < 13; i++) step(vt[i], i);
        chk("r7 final", rf[7], 32'h1);
        chk("r0 cleared", rf[0], 32'h0);
        chk("sb empty", sb.size(), 32'd0);

        // a transfer on a reset edge must be dropped
        req0_valid = 1'b1;
        req0_dst   = 5'd12;
        req0_data  = 32'h55;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        chk("rstacc we", {31'd0, RF_WRITE}, 32'd0);
        chk("rstacc dst", {27'd0, Rdst}, 32'd0);
        chk("rstacc data", RY, 32'd0);
        chk("rstacc busy", {31'd0, init_busy}, 32'd1);
        req0_valid = 1'b0;

        // abort the sweep at index 10, then restart from 0
        rst_n = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("abort idx", {27'd0, Rdst}, 32'd10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort we", {31'd0, RF_WRITE}, 32'd0);
        chk("abort dst", {27'd0, Rdst}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart we", {31'd0, RF_WRITE}, 32'd1);
        chk("restart dst", {27'd0, Rdst}, 32'd0);
        @(posedge clk);
        #1;
        chk("restart dst1", {27'd0, Rdst}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
